// File: rtl/poly_sched.sv
// poly_sched: round-robin issue of lane operands into a shared fixed-latency
// datapath, with tagged return into a credit-protected result FIFO.
module poly_sched #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_x,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      dp_x,
  output logic                  dp_valid,
  input  logic [WIDTH-1:0]      dp_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output logic [IW-1:0]         rsp_id
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IFW = $clog2(LAT + 1);

  logic [IW-1:0]    rr_ptr;
  logic [LAT-1:0]   tv;
  logic [IW-1:0]    tid [LAT];
  logic [WIDTH-1:0] my  [DEPTH];
  logic [IW-1:0]    mid [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic [IFW-1:0]   inflight;
  logic [IW-1:0]    gid;
  logic             hit, credit, issue, push, pop;
  int               idx;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++)
      inflight = inflight + IFW'(tv[i]);
  end

  // Entries in the tag pipe already own a FIFO slot.
  assign credit = (int'(count) + int'(inflight)) < DEPTH;

  always_comb begin
    hit = 1'b0;
    gid = '0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        gid = IW'(idx);
      end
    end
  end

  assign issue = hit && credit;

  always_comb begin
    req_ready = '0;
    dp_x      = '0;
    if (issue) begin
      req_ready[gid] = 1'b1;
      dp_x = req_x[int'(gid)*WIDTH +: WIDTH];
    end
  end

  assign dp_valid  = issue;
  assign push      = tv[LAT-1];
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_y     = my[rptr];
  assign rsp_id    = mid[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      tv     <= '0;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      for (int i = 0; i < LAT; i++)
        tid[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        my[i]  <= '0;
        mid[i] <= '0;
      end
    end else begin
      if (issue)
        rr_ptr <= (gid == IW'(NREQ-1)) ? '0 : gid + IW'(1);
      tv[0]  <= issue;
      tid[0] <= gid;
      for (int i = 1; i < LAT; i++) begin
        tv[i]  <= tv[i-1];
        tid[i] <= tid[i-1];
      end
      if (push) begin
        my[wptr]  <= dp_y;
        mid[wptr] <= tid[LAT-1];
        wptr <= (wptr == PW'(DEPTH-1)) ? '0 : wptr + PW'(1);
      end
      if (pop)
        rptr <= (rptr == PW'(DEPTH-1)) ? '0 : rptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

endmodule
